// File: rtl/seg_scan_decoder.sv
// Loopback monitor for a multiplexed seven-segment display: it filters the scanned
// sel/seg buses and rebuilds the displayed value as a packed nibble word.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned DIGITS        = 3,
    parameter int unsigned TIMEOUT       = 200_000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [7:0]            sel,
    input  logic [7:0]            seg,
    output logic [4*DIGITS-1:0]   data_out,
    output logic                  frame_done,
    output logic                  code_err,
    output logic                  stale
);

    localparam int unsigned       TW          = $clog2(TIMEOUT + 1);
    localparam logic [15:0]       STABLE_VAL  = 16'(STABLE_CYCLES);
    localparam logic [TW-1:0]     TIMEOUT_VAL = TW'(TIMEOUT);
    localparam logic [DIGITS-1:0] LOWER_MASK  = DIGITS'((1 << (DIGITS - 1)) - 1);

    typedef enum logic [0:0] {StSettle, StHold} state_t;

    logic [7:0]  sel_m, sel_q, seg_m, seg_q;
    logic [15:0] bus_prev;
    logic [15:0] stable_cnt_q, stable_cnt_d;
    logic        changed;

    state_t state_q, state_d;
    logic   take;

    logic [3:0] nib;
    logic       code_ok;
    logic       onehot;
    logic [2:0] idx;
    logic       in_range, last_pos, lower_ok, accept, commit;

    logic [DIGITS-1:0][3:0] shadow_q, shadow_d;
    logic [DIGITS-1:0]      seen_q, seen_d;
    logic [4*DIGITS-1:0]    data_out_d;
    logic                   frame_done_d, code_err_d, stale_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d;
    logic                   timeout_hit;

    // Two-stage synchronizers plus the previous value used for change detection.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sel_m        <= 8'h00;
            sel_q        <= 8'h00;
            seg_m        <= 8'h00;
            seg_q        <= 8'h00;
            bus_prev     <= 16'h0000;
            stable_cnt_q <= 16'h0000;
        end else begin
            sel_m        <= sel;
            sel_q        <= sel_m;
            seg_m        <= seg;
            seg_q        <= seg_m;
            bus_prev     <= {sel_q, seg_q};
            stable_cnt_q <= stable_cnt_d;
        end
    end

    // Counter holds the number of cycles the current {sel_q,seg_q} value has been seen.
    always_comb begin
        changed = ({sel_q, seg_q} != bus_prev);
        if (changed) begin
            stable_cnt_d = 16'd1;
        end else if (stable_cnt_q != 16'hFFFF) begin
            stable_cnt_d = stable_cnt_q + 16'd1;
        end else begin
            stable_cnt_d = stable_cnt_q;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StSettle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSettle: if (take)    state_d = StHold;
            StHold:   if (changed) state_d = StSettle;
            default:               state_d = StSettle;
        endcase
    end

    always_comb begin
        take = (state_q == StSettle) && !changed && (stable_cnt_d == STABLE_VAL);
    end

    always_comb begin
        code_ok = 1'b1;
        nib     = 4'h0;
        case (seg_q[6:0])
            7'h40: nib = 4'h0;
            7'h79: nib = 4'h1;
            7'h24: nib = 4'h2;
            7'h30: nib = 4'h3;
            7'h19: nib = 4'h4;
            7'h12: nib = 4'h5;
            7'h02: nib = 4'h6;
            7'h78: nib = 4'h7;
            7'h00: nib = 4'h8;
            7'h10: nib = 4'h9;
            7'h08: nib = 4'hA;
            7'h03: nib = 4'hB;
            7'h46: nib = 4'hC;
            7'h21: nib = 4'hD;
            7'h06: nib = 4'hE;
            7'h0E: nib = 4'hF;
            default: code_ok = 1'b0;
        endcase
    end

    always_comb begin
        onehot = (sel_q != 8'h00) && ((sel_q & (sel_q - 8'd1)) == 8'h00);
        idx    = 3'd0;
        for (int b = 0; b < 8; b++) begin
            if (sel_q[b]) idx = 3'(b);
        end
        in_range = ({1'b0, idx} < 4'(DIGITS));
        last_pos = in_range && (idx == 3'(DIGITS - 1));
        lower_ok = ((seen_q & LOWER_MASK) == LOWER_MASK);
        accept   = take && onehot && code_ok;
        commit   = accept && last_pos && lower_ok;
    end

    always_comb begin
        shadow_d     = shadow_q;
        seen_d       = seen_q;
        data_out_d   = data_out;
        frame_done_d = 1'b0;
        code_err_d   = take && !(onehot && code_ok);
        stale_d      = stale;
        to_cnt_d     = to_cnt_q;
        timeout_hit  = !accept && (to_cnt_q == TIMEOUT_VAL - TW'(1));

        if (accept) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TIMEOUT_VAL) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        if (timeout_hit) begin
            stale_d = 1'b1;
            seen_d  = '0;
        end

        if (accept && in_range) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (idx == 3'(d)) shadow_d[d] = nib;
            end
            if (commit) begin
                data_out_d   = shadow_d;
                frame_done_d = 1'b1;
                stale_d      = 1'b0;
                seen_d       = '0;
            end else begin
                for (int d = 0; d < DIGITS; d++) begin
                    if (idx == 3'(d)) seen_d[d] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            shadow_q   <= '0;
            seen_q     <= '0;
            data_out   <= '0;
            frame_done <= 1'b0;
            code_err   <= 1'b0;
            stale      <= 1'b1;
            to_cnt_q   <= '0;
        end else begin
            shadow_q   <= shadow_d;
            seen_q     <= seen_d;
            data_out   <= data_out_d;
            frame_done <= frame_done_d;
            code_err   <= code_err_d;
            stale      <= stale_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

endmodule
